// File: rtl/bounce_gen.sv
// Bouncing-point generator: a signed 2-D position advances by its velocity on
// each step strobe and reflects off configurable walls. A RUN/HOLD FSM gates
// stepping; position/velocity loads are accepted only while holding.
module bounce_gen #(
  parameter int W    = 8,
  parameter int XMIN = -38,
  parameter int XMAX = 38,
  parameter int YMIN = -38,
  parameter int YMAX = 38,
  parameter int X0   = -10,
  parameter int Y0   = 0,
  parameter int VX0  = 1,
  parameter int VY0  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         pause,
  input  logic         resume,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_x,
  input  logic [W-1:0] load_y,
  input  logic [W-1:0] load_vx,
  input  logic [W-1:0] load_vy,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] vx,
  output logic [W-1:0] vy,
  output logic         out_valid,
  output logic         bounce_x,
  output logic         bounce_y,
  output logic         running
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Most negative velocity has no positive counterpart; its negation saturates.
  localparam logic [W-1:0] V_MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] V_MOST_POS = {1'b0, {(W-1){1'b1}}};

  localparam logic [1:0][W-1:0] POS_RST = {Y0[W-1:0], X0[W-1:0]};
  localparam logic [1:0][W-1:0] VEL_RST = {VY0[W-1:0], VX0[W-1:0]};

  state_t state_reg, state_next;
  logic   step_acc, load_acc;

  // Index 0 is the x axis, index 1 the y axis.
  logic [1:0][W-1:0] pos_reg, pos_next;
  logic [1:0][W-1:0] vel_reg, vel_next;
  logic [1:0][W-1:0] load_pos, load_vel;
  logic [1:0]        bounce_reg, bounce_next;
  logic              valid_reg, valid_next;

  assign load_pos = {load_y, load_x};
  assign load_vel = {load_vy, load_vx};

  // FSM state register; reset returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and acceptance of step/load; pause beats resume and step.
  always_comb begin
    state_next = state_reg;
    step_acc   = 1'b0;
    load_acc   = 1'b0;
    case (state_reg)
      RUN: begin
        step_acc = step & ~pause;
        if (pause) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        load_acc = load_valid;
        if (resume & ~pause) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    valid_next = step_acc | load_acc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int AMIN  = (gi == 0) ? XMIN : YMIN;
      localparam int AMAX  = (gi == 0) ? XMAX : YMAX;
      localparam int AMIN2 = 2 * AMIN;
      localparam int AMAX2 = 2 * AMAX;
      localparam logic signed [W+1:0] MIN_E  = AMIN[W+1:0];
      localparam logic signed [W+1:0] MAX_E  = AMAX[W+1:0];
      localparam logic signed [W+1:0] MIN2_E = AMIN2[W+1:0];
      localparam logic signed [W+1:0] MAX2_E = AMAX2[W+1:0];

      logic signed [W+1:0] p_e, v_e, n_e, l_e, step_p, load_p;
      logic [W-1:0]        v_neg, step_v;
      logic                step_b;
      logic [W-1:0]        ax_pos_next, ax_vel_next;
      logic                ax_bounce_next;

      // Reflection arithmetic in W+2 bits so p+v and 2*wall-n never overflow.
      always_comb begin
        p_e    = signed'({{2{pos_reg[gi][W-1]}}, pos_reg[gi]});
        v_e    = signed'({{2{vel_reg[gi][W-1]}}, vel_reg[gi]});
        l_e    = signed'({{2{load_pos[gi][W-1]}}, load_pos[gi]});
        n_e    = p_e + v_e;
        v_neg  = (vel_reg[gi] == V_MOST_NEG) ? V_MOST_POS : -vel_reg[gi];
        step_p = n_e;
        step_v = vel_reg[gi];
        step_b = 1'b0;
        if (n_e > MAX_E) begin
          // Mirror about the upper wall; a huge velocity can overshoot the
          // lower wall after mirroring, in which case pin to that wall.
          step_p = MAX2_E - n_e;
          if (step_p < MIN_E) begin
            step_p = MIN_E;
          end
          step_v = v_neg;
          step_b = 1'b1;
        end else if (n_e < MIN_E) begin
          step_p = MIN2_E - n_e;
          if (step_p > MAX_E) begin
            step_p = MAX_E;
          end
          step_v = v_neg;
          step_b = 1'b1;
        end

        if (l_e > MAX_E) begin
          load_p = MAX_E;
        end else if (l_e < MIN_E) begin
          load_p = MIN_E;
        end else begin
          load_p = l_e;
        end

        ax_pos_next    = pos_reg[gi];
        ax_vel_next    = vel_reg[gi];
        ax_bounce_next = 1'b0;
        if (load_acc) begin
          ax_pos_next = load_p[W-1:0];
          ax_vel_next = load_vel[gi];
        end else if (step_acc) begin
          ax_pos_next    = step_p[W-1:0];
          ax_vel_next    = step_v;
          ax_bounce_next = step_b;
        end
      end

      // Both results are confined to [MIN,MAX], so the top guard bits are redundant.
      logic unused_guard_bits;
      assign unused_guard_bits = ^{step_p[W+1:W], load_p[W+1:W]};

      assign pos_next[gi]    = ax_pos_next;
      assign vel_next[gi]    = ax_vel_next;
      assign bounce_next[gi] = ax_bounce_next;
    end
  endgenerate

  // Datapath and event-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg    <= POS_RST;
      vel_reg    <= VEL_RST;
      bounce_reg <= 2'b00;
      valid_reg  <= 1'b0;
    end else begin
      pos_reg    <= pos_next;
      vel_reg    <= vel_next;
      bounce_reg <= bounce_next;
      valid_reg  <= valid_next;
    end
  end

  assign x          = pos_reg[0];
  assign y          = pos_reg[1];
  assign vx         = vel_reg[0];
  assign vy         = vel_reg[1];
  assign bounce_x   = bounce_reg[0];
  assign bounce_y   = bounce_reg[1];
  assign out_valid  = valid_reg;
  assign running    = (state_reg == RUN);
  assign load_ready = (state_reg == HOLD);

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: directed scenarios plus randomized traffic. A driver
// predicts each response from a plain-integer model and queues it; a monitor
// pops and compares whenever out_valid is presented.
module tb_bounce_gen;

  localparam int W    = 8;
  localparam int XMIN = -38;
  localparam int XMAX = 38;
  localparam int YMIN = -38;
  localparam int YMAX = 38;

  logic         clk = 1'b0;
  logic         rst, step, pause, resume, load_valid, load_ready;
  logic [W-1:0] load_x, load_y, load_vx, load_vy;
  logic [W-1:0] x, y, vx, vy;
  logic         out_valid, bounce_x, bounce_y, running;

  bounce_gen dut (
    .clk(clk), .rst(rst), .step(step), .pause(pause), .resume(resume),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
    .x(x), .y(y), .vx(vx), .vy(vy),
    .out_valid(out_valid), .bounce_x(bounce_x), .bounce_y(bounce_y),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int bx;
    int by;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference state: position, velocity, and whether the generator is holding.
  int mx, my, mvx, mvy;
  bit mhold;
  bit exp_valid;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int negsat(input int v);
    return (v == -(2 ** (W - 1))) ? (2 ** (W - 1)) - 1 : -v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // One axis of motion: move, mirror off a crossed wall, pin if still outside.
  function automatic void reflect(input int p, input int v, input int lo, input int hi,
                                  output int np, output int nv, output int b);
    int n;
    n  = p + v;
    np = n;
    nv = v;
    b  = 0;
    if (n > hi) begin
      np = clampi(2 * hi - n, lo, hi);
      nv = negsat(v);
      b  = 1;
    end else if (n < lo) begin
      np = clampi(2 * lo - n, lo, hi);
      nv = negsat(v);
      b  = 1;
    end
  endfunction

  // Drive one cycle of inputs, predict the response, then check per-cycle status.
  task automatic cycle(input bit r, input bit st, input bit pa, input bit re, input bit lv,
                       input int lx, input int ly, input int lvx, input int lvy);
    exp_t e;
    rst        = r;
    step       = st;
    pause      = pa;
    resume     = re;
    load_valid = lv;
    load_x     = lx[W-1:0];
    load_y     = ly[W-1:0];
    load_vx    = lvx[W-1:0];
    load_vy    = lvy[W-1:0];
    exp_valid  = 1'b0;
    if (r) begin
      mx = -10; my = 0; mvx = 1; mvy = 2; mhold = 1'b0;
    end else if (!mhold) begin
      if (st && !pa) begin
        reflect(mx, mvx, XMIN, XMAX, e.x, e.vx, e.bx);
        reflect(my, mvy, YMIN, YMAX, e.y, e.vy, e.by);
        mx = e.x; my = e.y; mvx = e.vx; mvy = e.vy;
        q.push_back(e);
        exp_valid = 1'b1;
      end
      if (pa) mhold = 1'b1;
    end else begin
      if (lv) begin
        e.x  = clampi(lx, XMIN, XMAX);
        e.y  = clampi(ly, YMIN, YMAX);
        e.vx = lvx;
        e.vy = lvy;
        e.bx = 0;
        e.by = 0;
        mx = e.x; my = e.y; mvx = e.vx; mvy = e.vy;
        q.push_back(e);
        exp_valid = 1'b1;
      end
      if (re && !pa) mhold = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", int'(out_valid), int'(exp_valid));
    chk("running", int'(running), int'(!mhold));
    chk("load_ready", int'(load_ready), int'(mhold));
  endtask

  task automatic do_step();
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_pause();
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_resume(input int lx, input int ly, input int lvx, input int lvy);
    cycle(0, 0, 0, 1, 1, lx, ly, lvx, lvy);
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey, input int evx, input int evy);
    chk({tag, "_x"}, int'($signed(x)), ex);
    chk({tag, "_y"}, int'($signed(y)), ey);
    chk({tag, "_vx"}, int'($signed(vx)), evx);
    chk({tag, "_vy"}, int'($signed(vy)), evy);
  endtask

  // Monitor: every presented output must match the oldest queued prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got out_valid=1 expected no pending output (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          chk("sb_x", int'($signed(x)), mon_e.x);
          chk("sb_y", int'($signed(y)), mon_e.y);
          chk("sb_vx", int'($signed(vx)), mon_e.vx);
          chk("sb_vy", int'($signed(vy)), mon_e.vy);
          chk("sb_bounce_x", int'(bounce_x), mon_e.bx);
          chk("sb_bounce_y", int'(bounce_y), mon_e.by);
          $display("txn x=%0d y=%0d vx=%0d vy=%0d bx=%0d by=%0d", $signed(x), $signed(y),
                   $signed(vx), $signed(vy), bounce_x, bounce_y);
        end
      end else begin
        chk("bounce_idle", int'({bounce_x, bounce_y}), 0);
      end
    end
  end

  initial begin
    int lx, ly, lvx, lvy;
    bit r, st, pa, re, lv;

    // Reset state and three plain steps.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_pos("rst", -10, 0, 1, 2);
    do_step(); do_step(); do_step();
    chk_pos("steps3", -7, 6, 1, 2);

    // Single-axis bounce off the upper x wall.
    do_pause();
    load_resume(37, 0, 3, 0);
    do_step();
    chk_pos("bounce_hi", 36, 0, -3, 0);
    chk("bounce_hi_bx", int'(bounce_x), 1);

    // Corner: both axes reflect in the same step.
    do_pause();
    load_resume(-38, 38, -1, 1);
    do_step();
    chk_pos("corner", -37, 37, 1, -1);
    chk("corner_bx", int'(bounce_x), 1);
    chk("corner_by", int'(bounce_y), 1);

    // Velocity beyond wall span: reflected point clamps to the far wall.
    do_pause();
    load_resume(38, 0, 127, 0);
    do_step();
    chk_pos("clamp", -38, 0, -127, 0);

    // Out-of-range load is clamped; exact wall hit does not bounce.
    do_pause();
    cycle(0, 0, 0, 0, 1, 100, -100, 0, 0);
    chk_pos("load_clamp", 38, -38, 0, 0);
    load_resume(30, 0, 8, 0);
    do_step();
    chk_pos("exact_wall", 38, 0, 8, 0);
    chk("exact_wall_bx", int'(bounce_x), 0);

    // Most-negative velocity saturates on reflection.
    do_pause();
    load_resume(0, 0, -128, 0);
    do_step();
    chk_pos("sat_neg", 38, 0, 127, 0);

    // pause+resume+step together: hold, no advance; load in RUN ignored.
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
    chk_pos("pr_step", 38, 0, 127, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5, 5, 5, 5);
    chk_pos("run_load", 38, 0, 127, 0);

    // Reset overrides load and step while holding.
    do_pause();
    cycle(1, 1, 0, 1, 1, 5, 5, 5, 5);
    chk_pos("rst_mid", -10, 0, 1, 2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(99) == 0);
      st  = ($urandom_range(9) < 6);
      pa  = ($urandom_range(9) < 1);
      re  = ($urandom_range(9) < 3);
      lv  = ($urandom_range(1) == 1);
      lx  = int'($urandom_range(255)) - 128;
      ly  = int'($urandom_range(255)) - 128;
      lvx = int'($urandom_range(255)) - 128;
      lvy = ($urandom_range(3) == 0) ? int'($urandom_range(255)) - 128
                                     : int'($urandom_range(20)) - 10;
      cycle(r, st, pa, re, lv, lx, ly, lvx, lvy);
    end

    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
